// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Single outstanding request: req/gnt accepts an address, rvalid/rdata returns it.
`timescale 1ns/1ps
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tracks the single
// outstanding response, parks a response in a hold buffer while ID stalls,
// and drives the IF/ID pipeline register.
`timescale 1ns/1ps
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        bubble_if,
   input  logic        new_pc_valid,
   input  logic [31:0] new_pc,
   if_stage_if.master  imem,
   output logic [31:0] pc_id,
   output logic [31:0] inst_id,
   output logic        valid_id
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc_f;
   logic [31:0] pc_wait;
   logic [31:0] hold_pc;
   logic [31:0] hold_inst;
   logic        drop;

   logic        accept;
   logic        resp_ok;
   logic        granted;
   logic [31:0] redirect_pc;
   logic        load_if;
   logic [31:0] load_pc;
   logic [31:0] load_inst;

   // ID can take a new instruction this cycle
   assign accept      = !stall_if && !bubble_if && !new_pc_valid;
   // Redirect targets are forced to a word boundary
   assign redirect_pc = new_pc & 32'hFFFF_FFFC;
   // A live (not cancelled) response is on the bus
   assign resp_ok     = (state == WAIT) && imem.imem_rvalid && !drop;

   // Fetch request: new request only when nothing is outstanding or the
   // outstanding response is being consumed by ID in this same cycle
   always_comb begin
      imem.imem_req = 1'b0;
      case (state)
         IDLE:    imem.imem_req = !new_pc_valid;
         WAIT:    imem.imem_req = resp_ok && accept;
         default: imem.imem_req = 1'b0;
      endcase
   end

   assign imem.imem_addr = pc_f;
   assign granted        = imem.imem_req && imem.imem_gnt;

   // Select the instruction offered to IF/ID: live response first, then hold buffer
   always_comb begin
      load_if   = 1'b0;
      load_pc   = hold_pc;
      load_inst = hold_inst;
      if (resp_ok && accept) begin
         load_if   = 1'b1;
         load_pc   = pc_wait;
         load_inst = imem.imem_rdata;
      end else if ((state == HOLD) && accept) begin
         load_if   = 1'b1;
      end
   end

   // Fetch control FSM, PC tracking, drop flag and hold buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc_f      <= RESET_PC;
         pc_wait   <= RESET_PC;
         hold_pc   <= 32'h0;
         hold_inst <= 32'h0;
         drop      <= 1'b0;
      end else begin
         if (granted) begin
            pc_wait <= pc_f;
            pc_f    <= pc_f + 32'd4;
         end
         // A redirect always wins over the sequential increment
         if (new_pc_valid) begin
            pc_f <= redirect_pc;
         end
         case (state)
            IDLE: begin
               if (granted) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  if (drop || new_pc_valid || bubble_if) begin
                     drop  <= 1'b0;
                     state <= IDLE;
                  end else if (stall_if) begin
                     hold_pc   <= pc_wait;
                     hold_inst <= imem.imem_rdata;
                     state     <= HOLD;
                  end else begin
                     state <= granted ? WAIT : IDLE;
                  end
               end else if (new_pc_valid) begin
                  // Response still in flight for the old path; discard it on arrival
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (!stall_if || bubble_if || new_pc_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // IF/ID register: bubble beats stall beats load; otherwise insert a NOP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_id    <= RESET_PC;
         inst_id  <= NOP_INST;
         valid_id <= 1'b0;
      end else if (bubble_if) begin
         inst_id  <= NOP_INST;
         valid_id <= 1'b0;
      end else if (!stall_if) begin
         if (load_if) begin
            pc_id    <= load_pc;
            inst_id  <= load_inst;
            valid_id <= 1'b1;
         end else begin
            inst_id  <= NOP_INST;
            valid_id <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a one-deep instruction memory model returning
// rdata = addr, with scoreboards for fetch addresses and IF/ID contents.
`timescale 1ns/1ps
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if;
   logic        bubble_if;
   logic        new_pc_valid;
   logic [31:0] new_pc;
   logic [31:0] pc_id;
   logic [31:0] inst_id;
   logic        valid_id;

   if_stage_if bus();

   if_stage #(
      .RESET_PC(RESET_PC),
      .NOP_INST(NOP_INST)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_if     (stall_if),
      .bubble_if    (bubble_if),
      .new_pc_valid (new_pc_valid),
      .new_pc       (new_pc),
      .imem         (bus),
      .pc_id        (pc_id),
      .inst_id      (inst_id),
      .valid_id     (valid_id)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] addr_q[$];

   // memory model state
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   int          mem_cnt  = 0;
   int          resp_delay = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: note the request accepted at the edge, advance the memory
   // model, then score the IF/ID register.
   task automatic tick();
      logic        g;
      logic [31:0] ga;
      logic        cs;
      logic        cb;
      logic [31:0] ppc;
      logic [31:0] pinst;
      logic        pv;
      logic [31:0] e;
      #1;
      g     = bus.imem_req && bus.imem_gnt && !rst;
      ga    = bus.imem_addr;
      cs    = stall_if;
      cb    = bubble_if;
      ppc   = pc_id;
      pinst = inst_id;
      pv    = valid_id;
      if (g) begin
         check("fetch_expected", 32'(addr_q.size() != 0), 32'd1);
         if (addr_q.size() != 0) begin
            e = addr_q.pop_front();
            check("fetch_addr", ga, e);
         end
      end
      @(posedge clk);
      #1;
      if (bus.imem_rvalid) begin
         bus.imem_rvalid = 1'b0;
      end
      if (g) begin
         mem_pend = 1'b1;
         mem_addr = ga;
         mem_cnt  = resp_delay;
      end
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_addr;
            mem_pend        = 1'b0;
         end else begin
            mem_cnt--;
         end
      end
      if (cb) begin
         check("bubble_inst", inst_id, NOP_INST);
         check("bubble_valid", 32'(valid_id), 32'd0);
         check("bubble_pc", pc_id, ppc);
      end else if (cs) begin
         check("stall_pc", pc_id, ppc);
         check("stall_inst", inst_id, pinst);
         check("stall_valid", 32'(valid_id), 32'(pv));
      end else if (valid_id) begin
         check("id_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc_id", pc_id, e);
            check("inst_id", inst_id, e);
         end
      end else begin
         check("empty_inst", inst_id, NOP_INST);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      stall_if        = 1'b0;
      bubble_if       = 1'b0;
      new_pc_valid    = 1'b0;
      new_pc          = 32'h0;
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;

      @(posedge clk);
      #1;
      check("rst_pc_id", pc_id, RESET_PC);
      check("rst_inst_id", inst_id, NOP_INST);
      check("rst_valid_id", 32'(valid_id), 32'd0);
      check("rst_imem_addr", bus.imem_addr, RESET_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // streaming fetch with a 1-cycle memory
      addr_q.push_back(32'h0);
      addr_q.push_back(32'h4);
      addr_q.push_back(32'h8);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      tick();
      check("latency_n1", 32'(valid_id), 32'd0);
      tick();
      check("latency_n2", 32'(valid_id), 32'd1);
      tick();

      // stall for three cycles while the response for 8 is on the bus
      stall_if = 1'b1;
      tick();
      check("hold_req", 32'(bus.imem_req), 32'd0);
      tick();
      tick();
      check("hold_pc_id", pc_id, 32'h4);
      stall_if = 1'b0;
      addr_q.push_back(32'hC);
      exp_q.push_back(32'h8);
      tick();
      check("release_inst", inst_id, 32'h8);

      // redirect while the response for 12 is delayed two cycles
      resp_delay = 2;
      tick();
      new_pc_valid = 1'b1;
      new_pc       = 32'h100;
      tick();
      new_pc_valid = 1'b0;
      resp_delay   = 0;
      tick();
      check("redir_gap_valid", 32'(valid_id), 32'd0);
      tick();
      check("redir_gap_valid2", 32'(valid_id), 32'd0);
      check("redir_addr", bus.imem_addr, 32'h100);
      addr_q.push_back(32'h100);
      addr_q.push_back(32'h104);
      exp_q.push_back(32'h100);
      tick();
      tick();

      // unaligned redirect together with a bubble
      bubble_if    = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 32'h203;
      tick();
      bubble_if    = 1'b0;
      new_pc_valid = 1'b0;
      check("bubble_redir_addr", bus.imem_addr, 32'h200);
      addr_q.push_back(32'h200);
      addr_q.push_back(32'h204);
      exp_q.push_back(32'h200);
      tick();
      tick();

      // redirect to the last word, then wrap
      new_pc_valid = 1'b1;
      new_pc       = 32'hFFFF_FFFC;
      tick();
      new_pc_valid = 1'b0;
      addr_q.push_back(32'hFFFF_FFFC);
      addr_q.push_back(32'h0);
      addr_q.push_back(32'h4);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      tick();
      tick();
      resp_delay = 2;
      tick();
      resp_delay = 0;

      // reset with a response still outstanding
      rst = 1'b1;
      #1;
      check("midrst_pc_id", pc_id, RESET_PC);
      check("midrst_inst_id", inst_id, NOP_INST);
      check("midrst_valid_id", 32'(valid_id), 32'd0);
      check("midrst_imem_addr", bus.imem_addr, RESET_PC);
      tick();
      rst          = 1'b0;
      bus.imem_gnt = 1'b0;
      tick();
      check("stale_rvalid_seen", 32'(bus.imem_rvalid), 32'd1);
      tick();
      check("stale_valid_id", 32'(valid_id), 32'd0);
      check("post_rst_addr", bus.imem_addr, RESET_PC);
      bus.imem_gnt = 1'b1;
      addr_q.push_back(32'h0);
      addr_q.push_back(32'h4);
      addr_q.push_back(32'h8);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      tick();
      tick();
      tick();

      check("exp_q_left", 32'(exp_q.size()), 32'd0);
      check("addr_q_left", 32'(addr_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction word placed in IF/ID on a bubble.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall_if  input  1  hold IF/ID contents; from hazard unit.
REQ-006 bubble_if  input  1  load a bubble into IF/ID; from hazard unit; priority over stall_if.
REQ-007 new_pc_valid  input  1  redirect request from ID (taken branch/jal/jalr).
REQ-008 new_pc  input  32  redirect target.
REQ-009 imem_req  output  1  fetch request.
REQ-010 imem_addr  output  32  fetch address, word aligned.
REQ-011 imem_gnt  input  1  request accepted this cycle.
REQ-012 imem_rvalid  input  1  response data valid; at most one outstanding request.
REQ-013 imem_rdata  input  32  fetched instruction.
REQ-014 pc_id  output  32  IF/ID register: PC of inst_id.
REQ-015 inst_id  output  32  IF/ID register: instruction.
REQ-016 valid_id  output  1  IF/ID register: 1 = real instruction, 0 = bubble.

Function
REQ-017 State: pc_f (next fetch PC), pc_wait (PC of outstanding request), hold buffer {hold_pc, hold_inst}, drop flag, FSM {IDLE, WAIT, HOLD}.
REQ-018 IDLE: imem_req=1, imem_addr=pc_f, unless new_pc_valid=1 (then imem_req=0); on imem_req&imem_gnt -> WAIT, pc_wait<=pc_f, pc_f<=pc_f+4 (mod 2^32); no grant -> stay IDLE, pc_f unchanged.
REQ-019 "Accept" = stall_if=0 and bubble_if=0 and new_pc_valid=0.
REQ-020 WAIT with imem_rvalid=1, drop=0, accept=1: IF/ID <= {pc_wait, imem_rdata, 1}; imem_req=1, imem_addr=pc_f same cycle; gnt -> stay WAIT (pc_wait<=pc_f, pc_f+=4), else -> IDLE.
REQ-021 WAIT with imem_rvalid=1, drop=0, stall_if=1, bubble_if=0, new_pc_valid=0: hold buffer <= {pc_wait, imem_rdata}; -> HOLD; imem_req=0.
REQ-022 WAIT with imem_rvalid=1 and (drop=1 or new_pc_valid=1 or bubble_if=1): response discarded, drop<=0, -> IDLE.
REQ-023 WAIT with imem_rvalid=0 and new_pc_valid=1: drop<=1, stay WAIT; in WAIT with rvalid=0, imem_req=0.
REQ-024 HOLD: imem_req=0; when stall_if=0 and bubble_if=0 and new_pc_valid=0: IF/ID <= {hold_pc, hold_inst, 1}, -> IDLE; bubble_if=1 or new_pc_valid=1: buffer discarded, -> IDLE.
REQ-025 Redirect (new_pc_valid=1) in any state: pc_f <= {new_pc[31:2], 2'b00} next edge; overrides pc_f+4 update.
REQ-026 IF/ID update priority: bubble_if -> {pc_id unchanged, NOP_INST, 0}; else stall_if -> hold all; else instruction available per REQ-020/024 -> load; else -> {pc_id unchanged, NOP_INST, 0}.
REQ-027 Redirect does not itself flush IF/ID; flush is by bubble_if only.
REQ-028 imem_rvalid in IDLE or HOLD: ignored, no state change.
REQ-029 Latency: IDLE grant at cycle N, rvalid at N+1 -> valid_id=1 at N+2; sustained 1 instruction/cycle with 1-cycle memory and no stalls.

Reset
REQ-030 rst=1 asynchronously: pc_f=RESET_PC, FSM=IDLE, drop=0, hold buffer=0, pc_id=RESET_PC, inst_id=NOP_INST, valid_id=0.
REQ-031 Reset mid-WAIT: outstanding response arriving after reset release is ignored (REQ-028); first request after release uses RESET_PC.

Verification
REQ-032 Reset release, gnt=1 always, 1-cycle rvalid, rdata=addr: imem_addr 0,4,8,... every cycle; pc_id/inst_id 0,4,8 from cycle 2, valid_id=1.
REQ-033 stall_if=1 for 3 cycles during WAIT rvalid of addr 8: FSM HOLD, IF/ID holds addr 4; after release inst_id=8, next request addr 12, no loss or duplicate.
REQ-034 new_pc_valid=1, new_pc=32'h100 while WAIT with rvalid delayed 2 cycles: late response (addr 12) discarded, next imem_addr=32'h100, valid_id=0 in between.
REQ-035 new_pc=32'h203 same cycle as bubble_if=1: inst_id=NOP_INST, valid_id=0; next fetch addr 32'h200.
REQ-036 pc_f=32'hFFFF_FFFC granted: next imem_addr=32'h0000_0000.
REQ-037 rst asserted mid-WAIT, response arrives after release: ignored; first fetch RESET_PC; outputs match REQ-030 during reset.
